// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: states, opcodes,
// datapath mux codes and the packed control word produced by the decoder.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RESET    = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WB   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_R_EXEC   = 4'd7,
    ST_R_WB     = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JUMP     = 4'd10,
    ST_JAL      = 4'd11,
    ST_I_EXEC   = 4'd12,
    ST_I_WB     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGT   = 6'b000111;
  localparam logic [5:0] OP_BGEZ  = 6'b000001;
  localparam logic [5:0] OP_BNEZ  = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_LUI   = 3'b100;

  localparam logic [1:0] PC_SRC_ALU  = 2'b00;
  localparam logic [1:0] PC_SRC_BR   = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP = 2'b10;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MDR = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC  = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       sign_ext;
    logic [1:0] branch_type;
    logic       illegal_op;
    logic       instr_done;
  } ctrl_t;

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BGT, OP_BGEZ, OP_BNEZ,
      OP_J, OP_JAL, OP_ADDI, OP_ORI, OP_LUI: is_legal = 1'b1;
      default:                               is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational output decoder: current state plus opcode/ready give the
// full control word (Moore outputs with Mealy ready/illegal qualifiers).
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl          = '0;
    ctrl.sign_ext = 1'b1;
    case (state)
      ST_RESET: ctrl.sign_ext = 1'b0;
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PC_SRC_ALU;
        end
      end
      ST_DECODE: begin
        // branch target is computed speculatively into ALUOut here
        ctrl.alu_src_b  = SRCB_IMM_SH;
        ctrl.alu_op     = ALU_ADD;
        ctrl.illegal_op = !is_legal(op);
        ctrl.instr_done = !is_legal(op);
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REG_DST_RT;
        ctrl.mem_to_reg = MEM_TO_REG_MDR;
        ctrl.instr_done = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      ST_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ST_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REG_DST_RD;
        ctrl.mem_to_reg = MEM_TO_REG_ALU;
        ctrl.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PC_SRC_BR;
        ctrl.instr_done    = 1'b1;
        case (op)
          OP_BGT:  ctrl.branch_type = 2'b01;
          OP_BGEZ: ctrl.branch_type = 2'b10;
          OP_BNEZ: ctrl.branch_type = 2'b11;
          default: ctrl.branch_type = 2'b00;
        endcase
      end
      ST_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PC_SRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      ST_JAL: begin
        // PC already holds PC+4, so it is the link value
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PC_SRC_JUMP;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REG_DST_RA;
        ctrl.mem_to_reg = MEM_TO_REG_PC;
        ctrl.instr_done = 1'b1;
      end
      ST_I_EXEC, ST_I_WB: begin
        // ALU op / extension held through write-back so ALUOut stays coherent
        case (op)
          OP_ORI:  begin ctrl.alu_op = ALU_OR;  ctrl.sign_ext = 1'b0; end
          OP_LUI:  begin ctrl.alu_op = ALU_LUI; ctrl.sign_ext = 1'b0; end
          default: begin ctrl.alu_op = ALU_ADD; ctrl.sign_ext = 1'b1; end
        endcase
        if (state == ST_I_EXEC) begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
        end else begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = REG_DST_RT;
          ctrl.mem_to_reg = MEM_TO_REG_ALU;
          ctrl.instr_done = 1'b1;
        end
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register and next-state logic; control
// outputs come from mc_ctrl_outdec.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_OP_W    = 3,
  parameter int MEM_WAIT_EN = 1,
  parameter int STATE_W     = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [5:0]          instr_op_i,
  input  logic                mem_ready_i,
  output logic                pc_write_o,
  output logic                pc_write_cond_o,
  output logic [1:0]          pc_src_o,
  output logic                i_or_d_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                ir_write_o,
  output logic                reg_write_o,
  output logic [1:0]          reg_dst_o,
  output logic [1:0]          mem_to_reg_o,
  output logic                alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                sign_ext_o,
  output logic [1:0]          branch_type_o,
  output logic                illegal_op_o,
  output logic                instr_done_o,
  output logic [STATE_W-1:0]  state_o
);

  state_t state, state_nx;
  ctrl_t  ctrl;
  logic   mem_rdy;

  assign mem_rdy = (MEM_WAIT_EN != 0) ? mem_ready_i : 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_RESET;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_RESET: state_nx = ST_FETCH;
      ST_FETCH: if (mem_rdy) state_nx = ST_DECODE;
      ST_DECODE: begin
        case (instr_op_i)
          OP_RTYPE:                          state_nx = ST_R_EXEC;
          OP_LW, OP_SW:                      state_nx = ST_MEM_ADDR;
          OP_BEQ, OP_BGT, OP_BGEZ, OP_BNEZ:  state_nx = ST_BRANCH;
          OP_J:                              state_nx = ST_JUMP;
          OP_JAL:                            state_nx = ST_JAL;
          OP_ADDI, OP_ORI, OP_LUI:           state_nx = ST_I_EXEC;
          default:                           state_nx = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR: state_nx = (instr_op_i == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   if (mem_rdy) state_nx = ST_MEM_WB;
      ST_MEM_WR:   if (mem_rdy) state_nx = ST_FETCH;
      ST_R_EXEC:   state_nx = ST_R_WB;
      ST_I_EXEC:   state_nx = ST_I_WB;
      ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_JUMP, ST_JAL, ST_I_WB:
                   state_nx = ST_FETCH;
      default:     state_nx = ST_RESET;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state     (state),
    .op        (instr_op_i),
    .mem_ready (mem_rdy),
    .ctrl      (ctrl)
  );

  assign pc_write_o      = ctrl.pc_write;
  assign pc_write_cond_o = ctrl.pc_write_cond;
  assign pc_src_o        = ctrl.pc_src;
  assign i_or_d_o        = ctrl.i_or_d;
  assign mem_read_o      = ctrl.mem_read;
  assign mem_write_o     = ctrl.mem_write;
  assign ir_write_o      = ctrl.ir_write;
  assign reg_write_o     = ctrl.reg_write;
  assign reg_dst_o       = ctrl.reg_dst;
  assign mem_to_reg_o    = ctrl.mem_to_reg;
  assign alu_src_a_o     = ctrl.alu_src_a;
  assign alu_src_b_o     = ctrl.alu_src_b;
  assign alu_op_o        = ALU_OP_W'(ctrl.alu_op);
  assign sign_ext_o      = ctrl.sign_ext;
  assign branch_type_o   = ctrl.branch_type;
  assign illegal_op_o    = ctrl.illegal_op;
  assign instr_done_o    = ctrl.instr_done;
  assign state_o         = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks the FSM through each instruction
// class with hand-computed state and control expectations.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst, rst_nw, ready;
  logic nw_ready = 1'b0;
  logic [5:0] op;
  int checks = 0, errors = 0, done_cnt = 0, n = 0;

  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic alu_src_a, sign_ext, illegal_op, instr_done;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b, branch_type;
  logic [2:0] alu_op;
  logic [3:0] state;

  logic nw_pc_write, nw_pc_write_cond, nw_i_or_d, nw_mem_read, nw_mem_write, nw_ir_write;
  logic nw_reg_write, nw_alu_src_a, nw_sign_ext, nw_illegal_op, nw_instr_done;
  logic [1:0] nw_pc_src, nw_reg_dst, nw_mem_to_reg, nw_alu_src_b, nw_branch_type;
  logic [2:0] nw_alu_op;
  logic [3:0] nw_state;

  logic [23:0] outs;
  assign outs = {pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write, ir_write,
                 reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, sign_ext,
                 branch_type, illegal_op, instr_done};

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk_i(clk), .rst_i(rst), .instr_op_i(op), .mem_ready_i(ready),
    .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .pc_src_o(pc_src),
    .i_or_d_o(i_or_d), .mem_read_o(mem_read), .mem_write_o(mem_write),
    .ir_write_o(ir_write), .reg_write_o(reg_write), .reg_dst_o(reg_dst),
    .mem_to_reg_o(mem_to_reg), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
    .alu_op_o(alu_op), .sign_ext_o(sign_ext), .branch_type_o(branch_type),
    .illegal_op_o(illegal_op), .instr_done_o(instr_done), .state_o(state)
  );

  multicycle_ctrl #(.MEM_WAIT_EN(0)) dut_nw (
    .clk_i(clk), .rst_i(rst_nw), .instr_op_i(op), .mem_ready_i(nw_ready),
    .pc_write_o(nw_pc_write), .pc_write_cond_o(nw_pc_write_cond), .pc_src_o(nw_pc_src),
    .i_or_d_o(nw_i_or_d), .mem_read_o(nw_mem_read), .mem_write_o(nw_mem_write),
    .ir_write_o(nw_ir_write), .reg_write_o(nw_reg_write), .reg_dst_o(nw_reg_dst),
    .mem_to_reg_o(nw_mem_to_reg), .alu_src_a_o(nw_alu_src_a), .alu_src_b_o(nw_alu_src_b),
    .alu_op_o(nw_alu_op), .sign_ext_o(nw_sign_ext), .branch_type_o(nw_branch_type),
    .illegal_op_o(nw_illegal_op), .instr_done_o(nw_instr_done), .state_o(nw_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    n++;
    if (instr_done === 1'b1) done_cnt++;
  endtask

  initial begin
    rst = 1'b1; rst_nw = 1'b1; ready = 1'b1; op = 6'b100011;
    // reset
    cyc(); cyc();
    chk("rst_state", state, 0);
    chk("rst_outs", outs, 0);
    rst = 1'b0;
    cyc();
    chk("fetch_state", state, 1);
    chk("fetch_mem_read", mem_read, 1);
    chk("fetch_ir_write", ir_write, 1);
    chk("fetch_alu_src_b", alu_src_b, 2'b01);

    // R-type
    op = 6'b000000; done_cnt = 0;
    chk("r_f_rw", reg_write, 0);
    cyc(); chk("r_decode", state, 2);  chk("r_d_rw", reg_write, 0);
    chk("r_d_alu_src_b", alu_src_b, 2'b11);
    cyc(); chk("r_exec", state, 7);    chk("r_e_rw", reg_write, 0);
    chk("r_e_alu_op", alu_op, 3'b010);
    cyc(); chk("r_wb", state, 8);      chk("r_wb_rw", reg_write, 1);
    chk("r_wb_reg_dst", reg_dst, 2'b01);
    cyc(); chk("r_back", state, 1);
    chk("r_done_cnt", done_cnt, 1);

    // lw with two wait cycles in MEM_RD
    op = 6'b100011; n = 0;
    cyc(); chk("lw_decode", state, 2);
    cyc(); chk("lw_addr", state, 3);
    ready = 1'b0;
    cyc(); chk("lw_rd1", state, 4); chk("lw_rd1_mr", mem_read, 1); chk("lw_rd1_iod", i_or_d, 1);
    cyc(); chk("lw_rd2", state, 4); chk("lw_rd2_mr", mem_read, 1);
    cyc(); chk("lw_rd3", state, 4); chk("lw_rd3_iod", i_or_d, 1);
    ready = 1'b1;
    cyc(); chk("lw_wb", state, 5); chk("lw_wb_m2r", mem_to_reg, 2'b01);
    chk("lw_wb_done", instr_done, 1);
    cyc(); chk("lw_back", state, 1);
    chk("lw_cycles", n, 7);

    // bnez
    op = 6'b000101;
    cyc(); chk("bnez_decode", state, 2);
    cyc(); chk("bnez_state", state, 9);
    chk("bnez_pwc", pc_write_cond, 1); chk("bnez_pc_src", pc_src, 2'b01);
    chk("bnez_alu_op", alu_op, 3'b001); chk("bnez_btype", branch_type, 2'b11);
    cyc(); chk("bnez_back", state, 1);

    // jal
    op = 6'b000011;
    cyc(); cyc(); chk("jal_state", state, 11);
    chk("jal_reg_dst", reg_dst, 2'b10); chk("jal_m2r", mem_to_reg, 2'b10);
    chk("jal_pc_write", pc_write, 1); chk("jal_pc_src", pc_src, 2'b10);
    cyc(); chk("jal_back", state, 1);

    // illegal opcode
    op = 6'b111111;
    cyc(); chk("ill_state", state, 2);
    chk("ill_flag", illegal_op, 1); chk("ill_done", instr_done, 1);
    chk("ill_rw", reg_write, 0); chk("ill_mw", mem_write, 0);
    cyc(); chk("ill_back", state, 1); chk("ill_flag_off", illegal_op, 0);

    // ori: zero-extend, held through write-back
    op = 6'b001101;
    cyc(); cyc(); chk("ori_exec", state, 12);
    chk("ori_e_alu_op", alu_op, 3'b011); chk("ori_e_sext", sign_ext, 0);
    chk("ori_e_srcb", alu_src_b, 2'b10);
    cyc(); chk("ori_wb", state, 13);
    chk("ori_wb_alu_op", alu_op, 3'b011); chk("ori_wb_sext", sign_ext, 0);
    chk("ori_wb_rw", reg_write, 1);
    cyc(); chk("ori_back", state, 1);

    // sw completing immediately
    op = 6'b101011;
    cyc(); cyc(); chk("sw_addr", state, 3);
    cyc(); chk("sw_wr", state, 6); chk("sw_mw", mem_write, 1); chk("sw_done", instr_done, 1);
    cyc(); chk("sw_back", state, 1);

    // reset during stalled sw
    cyc(); cyc();
    ready = 1'b0;
    cyc(); chk("swr_wr", state, 6); chk("swr_mw", mem_write, 1); chk("swr_no_done", instr_done, 0);
    rst = 1'b1;
    cyc(); chk("swr_rst_state", state, 0); chk("swr_rst_mw", mem_write, 0);
    chk("swr_rst_outs", outs, 0);
    rst = 1'b0; ready = 1'b1;
    cyc(); chk("swr_fetch", state, 1);

    // MEM_WAIT_EN=0 with ready tied low: lw in 5 cycles
    op = 6'b100011;
    rst_nw = 1'b0;
    cyc(); chk("nw_fetch", nw_state, 1); chk("nw_ir_write", nw_ir_write, 1);
    n = 0;
    cyc(); chk("nw_decode", nw_state, 2);
    cyc(); chk("nw_addr", nw_state, 3);
    cyc(); chk("nw_rd", nw_state, 4); chk("nw_rd_mr", nw_mem_read, 1);
    cyc(); chk("nw_wb", nw_state, 5); chk("nw_wb_done", nw_instr_done, 1);
    cyc(); chk("nw_back", nw_state, 1);
    chk("nw_cycles", n, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
